// File: rtl/exc_ctrl.sv
// Exception controller: merges invalid-opcode and prioritised IRQ requests, holds ELR/ESR and handler state.
// Define EXC_CTRL_IRQ_EDGE_EN for edge-triggered IRQs with pending latches; default is level-sensitive.
module exc_ctrl #(
  parameter int unsigned N_IRQ  = 4,
  parameter int unsigned PC_W   = 64,
  parameter logic [63:0] VECTOR = 64'hD8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic             not_an_instr,
  input  logic             eret,
  input  logic [PC_W-1:0]  pc,
  output logic             exc,
  output logic [PC_W-1:0]  exc_vector,
  output logic [PC_W-1:0]  elr,
  output logic [3:0]       esr,
  output logic             in_handler,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             double_fault
);

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_e;

  localparam logic [3:0] ESR_UNDEF = 4'b0010;

  state_e          state_q, state_d;
  logic [PC_W-1:0] elr_q, elr_d;
  logic [3:0]      esr_q, esr_d;
  logic            dfault_q, dfault_d;

  logic [N_IRQ-1:0] irq_req;
  logic [N_IRQ-1:0] irq_elig;
  logic [N_IRQ-1:0] ack_raw;
  logic [N_IRQ-1:0] ack;
  logic [2:0]       win_idx;
  logic             irq_hit;

`ifdef EXC_CTRL_IRQ_EDGE_EN
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pend_q, pend_d;

  // A fresh rising edge in the ack cycle re-arms the pending bit.
  always_comb begin
    pend_d = (pend_q & ~ack) | (irq & ~irq_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq;
      pend_q <= pend_d;
    end
  end

  assign irq_req = pend_q & irq_en;
`else
  assign irq_req = irq & irq_en;
`endif

  // Lowest-index eligible line wins; IRQs are masked while in the handler.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    irq_hit  = 1'b0;
    win_idx  = 3'd0;
    ack_raw  = '0;
    irq_elig = (state_q == IDLE) ? irq_req : '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (irq_elig[i] && !irq_hit) begin
        irq_hit    = 1'b1;
        win_idx    = 3'(i);
        ack_raw[i] = 1'b1;
      end
    end
    ack = (reset && !not_an_instr) ? ack_raw : '0;
  end

  assign exc = reset & (not_an_instr | irq_hit);

  always_comb begin
    state_d  = state_q;
    elr_d    = elr_q;
    esr_d    = esr_q;
    dfault_d = dfault_q;
    if (exc) begin
      elr_d   = pc;
      state_d = HANDLER;
      if (not_an_instr) begin
        esr_d = ESR_UNDEF;
        if (state_q == HANDLER) dfault_d = 1'b1;
      end else begin
        esr_d = {1'b1, win_idx};
      end
    end else if (eret && state_q == HANDLER) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and clears asynchronously on reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      elr_q    <= '0;
      esr_q    <= '0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      elr_q    <= elr_d;
      esr_q    <= esr_d;
      dfault_q <= dfault_d;
    end
  end

  assign exc_vector   = VECTOR[PC_W-1:0];
  assign elr          = elr_q;
  assign esr          = esr_q;
  assign in_handler   = (state_q == HANDLER);
  assign irq_ack      = ack;
  assign double_fault = dfault_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl; expected values are hand-derived from the block description.
module tb_exc_ctrl;

  localparam int N_IRQ = 4;
  localparam int PC_W  = 64;

  logic             clk;
  logic             reset;
  logic [N_IRQ-1:0] irq;
  logic [N_IRQ-1:0] irq_en;
  logic             not_an_instr;
  logic             eret;
  logic [PC_W-1:0]  pc;
  logic             exc;
  logic [PC_W-1:0]  exc_vector;
  logic [PC_W-1:0]  elr;
  logic [3:0]       esr;
  logic             in_handler;
  logic [N_IRQ-1:0] irq_ack;
  logic             double_fault;

  int n_checks = 0;
  int n_errors = 0;

  exc_ctrl #(.N_IRQ(N_IRQ), .PC_W(PC_W), .VECTOR(64'hD8)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .irq_en       (irq_en),
    .not_an_instr (not_an_instr),
    .eret         (eret),
    .pc           (pc),
    .exc          (exc),
    .exc_vector   (exc_vector),
    .elr          (elr),
    .esr          (esr),
    .in_handler   (in_handler),
    .irq_ack      (irq_ack),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    irq          = '0;
    irq_en       = 4'hF;
    not_an_instr = 1'b1;
    eret         = 1'b0;
    pc           = 64'h0;
    #2;
    check("rst_exc_gated", exc, 0);
    check("rst_ack_gated", irq_ack, 0);
    check("rst_elr", elr, 0);
    check("rst_esr", esr, 0);
    check("rst_in_handler", in_handler, 0);
    check("rst_dfault", double_fault, 0);
    check("vector", exc_vector, 64'hD8);
    not_an_instr = 1'b0;
    irq_en       = 4'h0;
    #11;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_exc", exc, 0);
      check("idle_elr", elr, 0);
      check("idle_esr", esr, 0);
      check("idle_in_handler", in_handler, 0);
    end
    irq_en = 4'hF;

`ifndef EXC_CTRL_IRQ_EDGE_EN
    // Invalid opcode from IDLE
    pc = 64'h40; not_an_instr = 1'b1; settle();
    check("undef_exc", exc, 1);
    check("undef_ack", irq_ack, 0);
    tick();
    not_an_instr = 1'b0;
    check("undef_elr", elr, 64'h40);
    check("undef_esr", esr, 4'b0010);
    check("undef_in_handler", in_handler, 1);
    check("undef_dfault", double_fault, 0);
    eret = 1'b1; settle();
    check("eret1_exc", exc, 0);
    tick();
    eret = 1'b0;
    check("eret1_idle", in_handler, 0);
    check("eret1_elr_hold", elr, 64'h40);
    check("eret1_esr_hold", esr, 4'b0010);

    // IRQ priority: lowest index of 1010 wins
    pc = 64'h100; irq = 4'b1010; settle();
    check("irq1_exc", exc, 1);
    check("irq1_ack", irq_ack, 4'b0010);
    tick();
    check("irq1_esr", esr, 4'b1001);
    check("irq1_elr", elr, 64'h100);
    check("irq1_in_handler", in_handler, 1);
    pc = 64'h104; irq = 4'b1000; settle();
    check("hnd_irq_masked", exc, 0);
    check("hnd_ack_zero", irq_ack, 0);
    eret = 1'b1; settle();
    check("eret2_exc", exc, 0);
    tick();
    eret = 1'b0; pc = 64'h108; settle();
    check("eret2_idle", in_handler, 0);
    check("irq3_exc", exc, 1);
    check("irq3_ack", irq_ack, 4'b1000);
    tick();
    irq = 4'b0000;
    check("irq3_esr", esr, 4'b1011);
    check("irq3_elr", elr, 64'h108);

    // Double fault: invalid opcode inside the handler
    pc = 64'hE0; not_an_instr = 1'b1; settle();
    check("df_exc", exc, 1);
    tick();
    not_an_instr = 1'b0;
    check("df_elr", elr, 64'hE0);
    check("df_esr", esr, 4'b0010);
    check("df_flag", double_fault, 1);
    check("df_in_handler", in_handler, 1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("df_eret_idle", in_handler, 0);
    check("df_sticky", double_fault, 1);

    // Disabled line is ignored
    irq_en = 4'b1110; irq = 4'b0001; settle();
    check("en_masked_exc", exc, 0);
    check("en_masked_ack", irq_ack, 0);

    // ERET in IDLE together with IRQ 0: exception wins
    irq_en = 4'hF; eret = 1'b1; pc = 64'h200; settle();
    check("eret_irq_exc", exc, 1);
    check("eret_irq_ack", irq_ack, 4'b0001);
    tick();
    eret = 1'b0; irq = 4'b0000;
    check("eret_irq_esr", esr, 4'b1000);
    check("eret_irq_hnd", in_handler, 1);
    check("eret_irq_elr", elr, 64'h200);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("eret3_idle", in_handler, 0);

    // Invalid opcode beats IRQs in IDLE
    irq = 4'b0110; not_an_instr = 1'b1; pc = 64'h300; settle();
    check("prio_exc", exc, 1);
    check("prio_ack", irq_ack, 0);
    tick();
    not_an_instr = 1'b0;
    check("prio_esr", esr, 4'b0010);
    check("prio_dfault", double_fault, 1);

    // Asynchronous reset mid-handler
    #2;
    reset = 1'b0; settle();
    check("arst_in_handler", in_handler, 0);
    check("arst_elr", elr, 0);
    check("arst_esr", esr, 0);
    check("arst_dfault", double_fault, 0);
    check("arst_exc_gated", exc, 0);
    check("arst_ack_gated", irq_ack, 0);
    irq = 4'b0000;
    #8;
    reset = 1'b1;
    tick();
    check("arst_release", in_handler, 0);
`else
    // Enter the handler via invalid opcode
    pc = 64'h40; not_an_instr = 1'b1;
    tick();
    not_an_instr = 1'b0;
    check("e_hnd", in_handler, 1);
    // One-cycle pulse on irq[2] during HANDLER
    irq = 4'b0100; settle();
    check("e_pulse_exc", exc, 0);
    tick();
    irq = 4'b0000; settle();
    check("e_pend_masked", exc, 0);
    check("e_pend_ack", irq_ack, 0);
    eret = 1'b1;
    tick();
    eret = 1'b0; pc = 64'h80; settle();
    check("e_eret_idle", in_handler, 0);
    check("e_pend_exc", exc, 1);
    check("e_pend_ack2", irq_ack, 4'b0100);
    tick();
    check("e_esr", esr, 4'b1010);
    check("e_elr", elr, 64'h80);
    eret = 1'b1;
    tick();
    eret = 1'b0; settle();
    check("e_pend_cleared", exc, 0);
    // Level-held line only fires once
    irq = 4'b0001;
    tick();
    settle();
    check("e_rise_exc", exc, 1);
    check("e_rise_ack", irq_ack, 4'b0001);
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0; settle();
    check("e_held_no_retake", exc, 0);
    irq = 4'b0000;
    // Reset mid-handler clears pending
    not_an_instr = 1'b1;
    tick();
    not_an_instr = 1'b0; irq = 4'b0010;
    tick();
    irq = 4'b0000;
    check("e_hnd2", in_handler, 1);
    reset = 1'b0; settle();
    check("e_arst_hnd", in_handler, 0);
    #8;
    reset = 1'b1;
    tick();
    check("e_arst_pend_clr", exc, 0);
    check("e_arst_dfault", double_fault, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
